// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit ALU and its accumulator sequencer.
//   WIDTH_DEF   : default datapath width
//   cmd_kind_t  : sequencer command kinds (LOAD, EXEC, CMP, CLR)
//   alu_op_t    : ALU op codes 0-7
//   state_t     : sequencer FSM states
package alu_pkg;

  localparam int WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    CMD_LOAD = 2'd0,
    CMD_EXEC = 2'd1,
    CMD_CMP  = 2'd2,
    CMD_CLR  = 2'd3
  } cmd_kind_t;

  typedef enum logic [2:0] {
    OP_ADD   = 3'd0,
    OP_SUB   = 3'd1,
    OP_AND   = 3'd2,
    OP_PASSX = 3'd3,
    OP_OR    = 3'd4,
    OP_XOR   = 3'd5,
    OP_NOTX  = 3'd6,
    OP_PASSY = 3'd7
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CAPT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Kinds that go through the ALU; the others complete at acceptance.
  function automatic logic is_alu_kind(input cmd_kind_t k);
    return (k == CMD_EXEC) || (k == CMD_CMP);
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational WIDTH-bit ALU.
//   op       : operation (alu_op_t)
//   in_x     : first operand
//   in_y     : second operand
//   out_s    : result, modulo 2^WIDTH
//   out_c    : carry out (ADD) / no-borrow (SUB); 0 for logic ops
//   zero     : out_s == 0
//   overflow : signed overflow (ADD/SUB); 0 for logic ops
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  output logic [WIDTH-1:0] out_s,
  output logic             out_c,
  output logic             zero,
  output logic             overflow
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum      = '0;
    out_s    = '0;
    out_c    = 1'b0;
    overflow = 1'b0;
    case (op)
      OP_ADD: begin
        sum      = {1'b0, in_x} + {1'b0, in_y};
        out_s    = sum[WIDTH-1:0];
        out_c    = sum[WIDTH];
        overflow = (in_x[WIDTH-1] == in_y[WIDTH-1]) && (out_s[WIDTH-1] != in_x[WIDTH-1]);
      end
      OP_SUB: begin
        // Two's-complement subtract: carry out = 1 means no borrow.
        sum      = {1'b0, in_x} + {1'b0, ~in_y} + {{WIDTH{1'b0}}, 1'b1};
        out_s    = sum[WIDTH-1:0];
        out_c    = sum[WIDTH];
        overflow = (in_x[WIDTH-1] != in_y[WIDTH-1]) && (out_s[WIDTH-1] != in_x[WIDTH-1]);
      end
      OP_AND:   out_s = in_x & in_y;
      OP_PASSX: out_s = in_x;
      OP_OR:    out_s = in_x | in_y;
      OP_XOR:   out_s = in_x ^ in_y;
      OP_NOTX:  out_s = ~in_x;
      default:  out_s = in_y;
    endcase
    zero = (out_s == '0);
  end

endmodule

// File: rtl/alu_acc_seq.sv
// Accumulator sequencer in front of the combinational alu.
// One command at a time (valid/ready); the accumulator drives alu_x and the
// command operand drives alu_y. ALU results/flags are captured two cycles
// after acceptance and presented downstream over a valid/ready handshake.
//   cmd_valid/cmd_ready        : command handshake (ready only in IDLE)
//   cmd_kind/cmd_op/cmd_data   : command kind, ALU op, operand
//   alu_op/alu_x/alu_y         : registered ALU inputs
//   alu_s/alu_c/alu_zero/alu_ovf : ALU outputs
//   res_valid/res_ready        : result handshake
//   res_data/res_c/res_z/res_v : result value and flags
//   acc                        : accumulator
//   ovf_sticky                 : OR of captured overflows since CLR/reset
module alu_acc_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_kind,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [2:0]       alu_op,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  input  logic [WIDTH-1:0] alu_s,
  input  logic             alu_c,
  input  logic             alu_zero,
  input  logic             alu_ovf,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_c,
  output logic             res_z,
  output logic             res_v,
  output logic [WIDTH-1:0] acc,
  output logic             ovf_sticky
);

  state_t    state, state_nxt;
  cmd_kind_t kind_q;
  cmd_kind_t kind_in;
  logic      accept;

  assign kind_in   = cmd_kind_t'(cmd_kind);
  assign cmd_ready = (state == ST_IDLE);
  assign res_valid = (state == ST_RESP);
  assign accept    = cmd_valid && cmd_ready;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (cmd_valid) state_nxt = is_alu_kind(kind_in) ? ST_DRIVE : ST_RESP;
      ST_DRIVE: state_nxt = ST_CAPT;
      ST_CAPT:  state_nxt = ST_RESP;
      ST_RESP:  if (res_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Datapath. ALU inputs are loaded for every accepted command and then held,
  // so the combinational ALU settles during DRIVE and is sampled in CAPT.
  // res_* only change at acceptance or CAPT, hence stable through RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kind_q     <= CMD_LOAD;
      alu_op     <= '0;
      alu_x      <= '0;
      alu_y      <= '0;
      acc        <= '0;
      res_data   <= '0;
      res_c      <= 1'b0;
      res_z      <= 1'b0;
      res_v      <= 1'b0;
      ovf_sticky <= 1'b0;
    end else if (accept) begin
      kind_q <= kind_in;
      alu_op <= cmd_op;
      alu_x  <= acc;
      alu_y  <= cmd_data;
      case (kind_in)
        CMD_LOAD: begin
          acc      <= cmd_data;
          res_data <= cmd_data;
          res_c    <= 1'b0;
          res_v    <= 1'b0;
          res_z    <= (cmd_data == '0);
        end
        CMD_CLR: begin
          acc        <= '0;
          res_data   <= '0;
          res_c      <= 1'b0;
          res_v      <= 1'b0;
          res_z      <= 1'b1;
          ovf_sticky <= 1'b0;
        end
        default: ;
      endcase
    end else if (state == ST_CAPT) begin
      res_data <= alu_s;
      res_c    <= alu_c;
      res_z    <= alu_zero;
      res_v    <= alu_ovf;
      if (alu_ovf)             ovf_sticky <= 1'b1;
      if (kind_q == CMD_EXEC)  acc        <= alu_s;
    end
  end

endmodule

// File: tb/tb_alu_acc_seq.sv
module tb_alu_acc_seq;
  import alu_pkg::*;

  localparam int W = WIDTH_DEF;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cmd_valid, cmd_ready;
  logic [1:0]   cmd_kind;
  logic [2:0]   cmd_op;
  logic [W-1:0] cmd_data;
  logic [2:0]   alu_op;
  logic [W-1:0] alu_x, alu_y, alu_s;
  logic         alu_c, alu_zero, alu_ovf;
  logic         res_valid, res_ready;
  logic [W-1:0] res_data;
  logic         res_c, res_z, res_v;
  logic [W-1:0] acc;
  logic         ovf_sticky;

  alu_acc_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_kind(cmd_kind), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .alu_op(alu_op), .alu_x(alu_x), .alu_y(alu_y),
    .alu_s(alu_s), .alu_c(alu_c), .alu_zero(alu_zero), .alu_ovf(alu_ovf),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_c(res_c), .res_z(res_z), .res_v(res_v),
    .acc(acc), .ovf_sticky(ovf_sticky)
  );

  alu #(.WIDTH(W)) u_alu (
    .op(alu_op), .in_x(alu_x), .in_y(alu_y),
    .out_s(alu_s), .out_c(alu_c), .zero(alu_zero), .overflow(alu_ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Wait for cmd_ready (bounded), present the command, return the cycle of acceptance.
  task automatic accept(input logic [1:0] k, input logic [2:0] op, input logic [W-1:0] d,
                        output int at);
    int n;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: cmd_ready got 0 expected 1");
    end
    cmd_valid = 1'b1;
    cmd_kind  = k;
    cmd_op    = op;
    cmd_data  = d;
    @(posedge clk);
    #1;
    at = cyc;
    cmd_valid = 1'b0;
  endtask

  // Edges from acceptance (inclusive) until res_valid is seen.
  task automatic wait_res(output int lat);
    lat = 1;
    @(negedge clk);
    while (!res_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!res_valid) begin
      checks++;
      failures++;
      $display("FAIL res_timeout: res_valid got 0 expected 1");
    end
  endtask

  typedef struct {
    logic [1:0]   kind;
    logic [2:0]   op;
    logic [W-1:0] data;
    int           lat;
    logic [W-1:0] rd;
    logic         c, z, v;
    logic [W-1:0] acc;
    logic         st;
  } vec_t;

  vec_t vt[15];

  initial begin
    int lat, t0, t1, t2, hi;

    //            kind      op  data     lat rd       c     z     v     acc      st
    vt[0]  = '{CMD_LOAD, 3'd0, 4'b0111, 1, 4'b0111, 1'b0, 1'b0, 1'b0, 4'b0111, 1'b0};
    vt[1]  = '{CMD_EXEC, 3'd0, 4'b0001, 3, 4'b1000, 1'b0, 1'b0, 1'b1, 4'b1000, 1'b1};
    vt[2]  = '{CMD_LOAD, 3'd0, 4'b0011, 1, 4'b0011, 1'b0, 1'b0, 1'b0, 4'b0011, 1'b1};
    vt[3]  = '{CMD_EXEC, 3'd0, 4'b1101, 3, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1};
    vt[4]  = '{CMD_LOAD, 3'd0, 4'b1000, 1, 4'b1000, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b1};
    vt[5]  = '{CMD_CMP,  3'd1, 4'b0001, 3, 4'b0111, 1'b1, 1'b0, 1'b1, 4'b1000, 1'b1};
    vt[6]  = '{CMD_CLR,  3'd0, 4'b1010, 1, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0};
    vt[7]  = '{CMD_LOAD, 3'd0, 4'b1111, 1, 4'b1111, 1'b0, 1'b0, 1'b0, 4'b1111, 1'b0};
    vt[8]  = '{CMD_EXEC, 3'd1, 4'b1111, 3, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0};
    vt[9]  = '{CMD_EXEC, 3'd7, 4'b0110, 3, 4'b0110, 1'b0, 1'b0, 1'b0, 4'b0110, 1'b0};
    vt[10] = '{CMD_EXEC, 3'd2, 4'b0011, 3, 4'b0010, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b0};
    vt[11] = '{CMD_LOAD, 3'd0, 4'b0000, 1, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0};
    vt[12] = '{CMD_LOAD, 3'd0, 4'b0110, 1, 4'b0110, 1'b0, 1'b0, 1'b0, 4'b0110, 1'b0};
    vt[13] = '{CMD_EXEC, 3'd0, 4'b0110, 3, 4'b1100, 1'b0, 1'b0, 1'b1, 4'b1100, 1'b1};
    vt[14] = '{CMD_CMP,  3'd1, 4'b0111, 3, 4'b0101, 1'b1, 1'b0, 1'b1, 4'b1100, 1'b1};

    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_kind = 2'd0;
    cmd_op = 3'd0;
    cmd_data = '0;
    res_ready = 1'b1;

    // Reset state
    #12;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_acc", acc, 0);
    chk("rst_res", {res_data, res_c, res_z, res_v, ovf_sticky}, 0);
    chk("rst_alu_in", {alu_op, alu_x, alu_y}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven commands, accumulator carried from one vector to the next
    for (int i = 0; i < 15; i++) begin
      accept(vt[i].kind, vt[i].op, vt[i].data, t0);
      wait_res(lat);
      chk($sformatf("v%0d_lat", i), lat, vt[i].lat);
      chk($sformatf("v%0d_data", i), res_data, vt[i].rd);
      chk($sformatf("v%0d_flags_czv", i), {res_c, res_z, res_v}, {vt[i].c, vt[i].z, vt[i].v});
      chk($sformatf("v%0d_acc", i), acc, vt[i].acc);
      chk($sformatf("v%0d_sticky", i), ovf_sticky, vt[i].st);
      @(negedge clk);
      chk($sformatf("v%0d_valid_1cyc", i), res_valid, 0);
      chk($sformatf("v%0d_ready_after", i), cmd_ready, 1);
    end

    // Backpressure: result held 5 cycles, stray command ignored
    res_ready = 1'b0;
    accept(CMD_LOAD, 3'd0, 4'b1010, t0);
    wait_res(lat);
    for (int k = 0; k < 5; k++) begin
      if (k == 1) begin
        cmd_valid = 1'b1;
        cmd_kind  = CMD_CLR;
        cmd_data  = 4'b0000;
      end
      if (k == 2) cmd_valid = 1'b0;
      chk($sformatf("hold%0d_valid", k), res_valid, 1);
      chk($sformatf("hold%0d_ready", k), cmd_ready, 0);
      chk($sformatf("hold%0d_res", k), {res_data, res_c, res_z, res_v}, {4'b1010, 3'b000});
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    chk("hold_release_valid", res_valid, 0);
    chk("hold_acc_kept", acc, 4'b1010);
    chk("hold_sticky_kept", ovf_sticky, 1);

    // Asynchronous reset during CAPT of an EXEC
    accept(CMD_EXEC, 3'd0, 4'b0001, t0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_cmd_ready", cmd_ready, 1);
    chk("arst_res_valid", res_valid, 0);
    chk("arst_acc", acc, 0);
    chk("arst_res", {res_data, res_c, res_z, res_v, ovf_sticky}, 0);
    chk("arst_alu_in", {alu_op, alu_x, alu_y}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    hi = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (res_valid) hi++;
    end
    chk("arst_no_valid", hi, 0);
    chk("arst_acc_after", acc, 0);

    // Back-to-back stream with res_ready high
    accept(CMD_LOAD, 3'd0, 4'b0101, t0);
    wait_res(lat);
    chk("s0_data", {res_data, res_z}, {4'b0101, 1'b0});
    accept(CMD_EXEC, 3'd5, 4'b0101, t1);
    wait_res(lat);
    chk("s1_data", {res_data, res_z}, {4'b0000, 1'b1});
    accept(CMD_EXEC, 3'd4, 4'b1100, t2);
    wait_res(lat);
    chk("s2_data", {res_data, res_z}, {4'b1100, 1'b0});
    chk("s_gap_load", t1 - t0, 2);
    chk("s_gap_exec", t2 - t1, 4);
    chk("s_acc", acc, 4'b1100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
